intr_ctrl: RTL and testbench

Interrupt controller for the MIPS core: the responder side of the RES (resume) instruction decoded by the control unit. It latches peripheral interrupt edges, arbitrates them by fixed priority and requests a jump to the ISR vector. It saves the interrupted PC and redirects fetch back to it when the core retires RES and raises `irq_resume`. It sits beside the datapath PC mux; nesting is not supported.

---
 rtl/intr_ctrl.sv | 121 ++++++++++++
 tb/tb_intr_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-latched, fixed-priority interrupt controller with
// single-level service, EPC save and one-cycle resume redirect.
module intr_ctrl #(
    parameter int          NUM_IRQ       = 3,
    parameter logic [31:0] VECTOR_BASE   = 32'h0000_0200,
    parameter logic [31:0] VECTOR_STRIDE = 32'h0000_0040
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               cpu_ack,
    input  logic [31:0]        pc_in,
    input  logic               irq_resume,
    output logic               cpu_irq,
    output logic [31:0]        isr_addr,
    output logic [31:0]        epc,
    output logic               epc_sel,
    output logic [2:0]         irq_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic               in_service
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_SERVICE,
        S_RETURN
    } state_t;

    state_t             state_q;
    logic [NUM_IRQ-1:0] req_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] arb;
    logic [NUM_IRQ-1:0] clr;
    logic [2:0]         win;
    logic [2:0]         irq_id_q;
    logic [31:0]        epc_q;
    logic               cpu_irq_q;
    logic               epc_sel_q;
    logic               in_svc_q;
    logic               take;

    // Arbitration, ack-clear and pending update; a new edge beats a clear.
    always_comb begin
        arb  = pending_q & irq_en;
        win  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (arb[i]) win = 3'(i);
        end
        take = (state_q == S_PEND) && cpu_ack;
        clr  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr[i] = take && (irq_id_q == 3'(i));
        end
        pending_d = (pending_q & ~clr) | (irq_req & ~req_q);
    end

    // Request edge history and latched pending bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q     <= '0;
            pending_q <= '0;
        end else begin
            req_q     <= irq_req;
            pending_q <= pending_d;
        end
    end

    // Service sequencer with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            irq_id_q  <= '0;
            epc_q     <= '0;
            cpu_irq_q <= 1'b0;
            epc_sel_q <= 1'b0;
            in_svc_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (|arb) begin
                        irq_id_q  <= win;
                        cpu_irq_q <= 1'b1;
                        state_q   <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (cpu_ack) begin
                        epc_q     <= pc_in;
                        cpu_irq_q <= 1'b0;
                        in_svc_q  <= 1'b1;
                        state_q   <= S_SERVICE;
                    end
                end
                S_SERVICE: begin
                    if (irq_resume) begin
                        in_svc_q  <= 1'b0;
                        epc_sel_q <= 1'b1;
                        state_q   <= S_RETURN;
                    end
                end
                S_RETURN: begin
                    epc_sel_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cpu_irq    = cpu_irq_q;
    assign epc        = epc_q;
    assign epc_sel    = epc_sel_q;
    assign irq_id     = irq_id_q;
    assign pending    = pending_q;
    assign in_service = in_svc_q;
    assign isr_addr   = VECTOR_BASE + 32'(irq_id_q) * VECTOR_STRIDE;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a flag-based behavioural model.
module tb_intr_ctrl;

    localparam int          N      = 3;
    localparam logic [31:0] VBASE  = 32'h0000_0200;
    localparam logic [31:0] VSTR   = 32'h0000_0040;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  irq_req = '0;
    logic [N-1:0]  irq_en = '0;
    logic          cpu_ack = 1'b0;
    logic [31:0]   pc_in = '0;
    logic          irq_resume = 1'b0;
    logic          cpu_irq;
    logic [31:0]   isr_addr;
    logic [31:0]   epc;
    logic          epc_sel;
    logic [2:0]    irq_id;
    logic [N-1:0]  pending;
    logic          in_service;

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;

    intr_ctrl #(
        .NUM_IRQ(N),
        .VECTOR_BASE(VBASE),
        .VECTOR_STRIDE(VSTR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .irq_req(irq_req),
        .irq_en(irq_en),
        .cpu_ack(cpu_ack),
        .pc_in(pc_in),
        .irq_resume(irq_resume),
        .cpu_irq(cpu_irq),
        .isr_addr(isr_addr),
        .epc(epc),
        .epc_sel(epc_sel),
        .irq_id(irq_id),
        .pending(pending),
        .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: flags for "requesting", "in ISR", "returning".
    logic [N-1:0] m_pend, m_prev;
    logic [2:0]   m_id;
    logic [31:0]  m_epc;
    bit           m_irq, m_svc, m_ret;

    always @(posedge clk or posedge rst) begin
        logic [N-1:0] rise;
        logic [N-1:0] clr;
        if (rst) begin
            m_pend = '0; m_prev = '0; m_id = '0; m_epc = '0;
            m_irq = 0; m_svc = 0; m_ret = 0;
        end else begin
            rise = irq_req & ~m_prev;
            m_prev = irq_req;
            clr = '0;
            if (m_irq) begin
                if (cpu_ack) begin
                    m_epc = pc_in;
                    clr[m_id] = 1'b1;
                    m_irq = 0;
                    m_svc = 1;
                end
            end else if (m_svc) begin
                if (irq_resume) begin
                    m_svc = 0;
                    m_ret = 1;
                end
            end else if (m_ret) begin
                m_ret = 0;
            end else begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (m_pend[i] && irq_en[i]) begin
                        m_id = 3'(i);
                        m_irq = 1;
                    end
                end
            end
            m_pend = (m_pend & ~clr) | rise;
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("cpu_irq", 32'(cpu_irq), 32'(m_irq));
            check("in_service", 32'(in_service), 32'(m_svc));
            check("epc_sel", 32'(epc_sel), 32'(m_ret));
            check("irq_id", 32'(irq_id), 32'(m_id));
            check("pending", 32'(pending), 32'(m_pend));
            check("epc", epc, m_epc);
            check("isr_addr", isr_addr, VBASE + 32'(m_id) * VSTR);
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        cmp_on = 1'b1;
        check("rst_isr", isr_addr, 32'h200);
        check("rst_pend", 32'(pending), 32'h0);
        irq_en = 3'b111;

        // Single source round trip.
        irq_req = 3'b010;
        tick();
        check("t1_pend", 32'(pending), 32'h2);
        check("t1_irq0", 32'(cpu_irq), 32'h0);
        irq_req = 3'b000;
        tick();
        check("t1_irq", 32'(cpu_irq), 32'h1);
        check("t1_id", 32'(irq_id), 32'h1);
        check("t1_isr", isr_addr, 32'h240);
        cpu_ack = 1'b1; pc_in = 32'h34;
        tick();
        cpu_ack = 1'b0;
        check("t2_epc", epc, 32'h34);
        check("t2_svc", 32'(in_service), 32'h1);
        check("t2_pend", 32'(pending), 32'h0);
        irq_resume = 1'b1;
        tick();
        irq_resume = 1'b0;
        check("t2_sel", 32'(epc_sel), 32'h1);
        tick();
        check("t2_sel0", 32'(epc_sel), 32'h0);

        // Simultaneous sources 2 and 0.
        irq_req = 3'b101;
        tick();
        irq_req = 3'b000;
        tick();
        check("t3_isr0", isr_addr, 32'h200);
        cpu_ack = 1'b1; pc_in = 32'h100;
        tick();
        cpu_ack = 1'b0; irq_resume = 1'b1;
        tick();
        irq_resume = 1'b0;
        tick(2);
        check("t3_irq2", 32'(cpu_irq), 32'h1);
        check("t3_isr2", isr_addr, 32'h280);
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0; irq_resume = 1'b1;
        tick();
        irq_resume = 1'b0;
        tick(2);

        // Masked source stays pending until enabled.
        irq_en = 3'b101;
        irq_req = 3'b010;
        tick();
        irq_req = 3'b000;
        tick(3);
        check("t4_pend", 32'(pending[1]), 32'h1);
        check("t4_irq0", 32'(cpu_irq), 32'h0);
        irq_en = 3'b111;
        tick(2);
        check("t4_irq1", 32'(cpu_irq), 32'h1);

        // Edge on acked source in the ack cycle keeps it pending.
        cpu_ack = 1'b1; irq_req = 3'b010;
        tick();
        cpu_ack = 1'b0;
        check("t5_pend", 32'(pending[1]), 32'h1);
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        check("t5_svc", 32'(in_service), 32'h1);
        irq_resume = 1'b1;
        tick();
        irq_resume = 1'b0;
        tick(2);
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0; irq_resume = 1'b1;
        tick();
        irq_resume = 1'b0;
        tick(4);
        check("t5_held", 32'(pending), 32'h0);
        check("t5_idle", 32'(cpu_irq), 32'h0);
        irq_resume = 1'b1;
        tick();
        irq_resume = 1'b0;
        check("t5_spur", 32'(epc_sel), 32'h0);
        irq_req = 3'b000;
        tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) irq_req = N'($urandom);
            if ($urandom_range(0, 15) == 0) irq_en = N'($urandom);
            cpu_ack = ($urandom_range(0, 2) == 0);
            irq_resume = ($urandom_range(0, 3) == 0);
            pc_in = $urandom;
            tick();
        end
        cpu_ack = 1'b0; irq_resume = 1'b0;

        // Asynchronous reset in the middle of service.
        irq_en = 3'b111;
        irq_req = 3'b000;
        tick();
        irq_req = 3'b100;
        tick(8);
        while (!cpu_irq && !in_service) tick();
        cpu_ack = 1'b1; pc_in = 32'hDEAD_BEE0;
        tick();
        cpu_ack = 1'b0;
        if (!in_service) begin
            irq_resume = 1'b0;
            cpu_ack = 1'b1;
            tick();
            cpu_ack = 1'b0;
        end
        check("t6_svc", 32'(in_service), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("t6_svc0", 32'(in_service), 32'h0);
        check("t6_irq0", 32'(cpu_irq), 32'h0);
        check("t6_epc0", epc, 32'h0);
        check("t6_pend0", 32'(pending), 32'h0);
        check("t6_id0", 32'(irq_id), 32'h0);
        check("t6_isr", isr_addr, VBASE);
        tick(2);
        rst = 1'b0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
